lbist_controller: RTL and testbench

Sequences one LBIST session: seeds and steps the test pattern generator (TPG), counts ones in the circuit-under-test (CUT) response stream, and compares the final ones count against a golden value. It sits between the top-level test request and the TPG/CUT/ORA datapath. It reports busy, a one-cycle done pulse and a sticky pass flag.

---
 rtl/lbist_pkg.sv | 18 +
 rtl/lbist_ones_counter.sv | 23 ++
 rtl/lbist_controller.sv | 143 ++++++++++++++
 tb/tb_lbist_controller.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/lbist_pkg.sv
// Shared LBIST types: controller state encoding and response-latency limits
// used by the controller and the TPG/ORA datapath blocks.
package lbist_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } lbist_state_e;

  localparam int RESP_LAT_MIN = 1;
  localparam int RESP_LAT_MAX = 8;
  localparam int DRAIN_W      = $clog2(RESP_LAT_MAX + 1);

endpackage

// File: rtl/lbist_ones_counter.sv
// ORA ones counter: wraps modulo 2^CNT_BITS; clear has priority over increment.
// Single-cycle update, no backpressure.
module lbist_ones_counter #(
  parameter int CNT_BITS = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/lbist_controller.sv
// LBIST session sequencer: seed, N pattern cycles, RESP_LAT drain, golden compare.
// Done arrives N+RESP_LAT+3 cycles after start is accepted; no backpressure.
module lbist_controller
  import lbist_pkg::*;
#(
  parameter int PAT_BITS = 16,
  parameter int CNT_BITS = 32,
  parameter int RESP_LAT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [PAT_BITS-1:0] num_patterns,
  input  logic [CNT_BITS-1:0] golden,
  input  logic                resp_bit,
  output logic                tpg_load,
  output logic                tpg_en,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_BITS-1:0] ones_count
);

  lbist_state_e          state, state_nxt;
  logic [PAT_BITS-1:0]   num_q;
  logic [CNT_BITS-1:0]   golden_q;
  logic [PAT_BITS-1:0]   pat_cnt;
  logic [PAT_BITS-1:0]   pat_nxt;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [RESP_LAT-1:0]   vpipe;
  logic                  accept;
  logic                  abort_take;

  assign pat_nxt = pat_cnt + PAT_BITS'(1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    tpg_load   = 1'b0;
    tpg_en     = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    accept     = 1'b0;
    abort_take = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          accept    = 1'b1;
          state_nxt = SEED;
        end
      end
      SEED: begin
        tpg_load  = 1'b1;
        state_nxt = (num_q == '0) ? DRAIN : RUN;
      end
      RUN: begin
        tpg_en = 1'b1;
        if (pat_nxt == num_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_W'(RESP_LAT - 1)) state_nxt = CHECK;
      end
      CHECK:   state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort && (state inside {SEED, RUN, DRAIN, CHECK})) begin
      abort_take = 1'b1;
      state_nxt  = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      num_q    <= '0;
      golden_q <= '0;
    end else if (accept) begin
      num_q    <= num_patterns;
      golden_q <= golden;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_cnt <= '0;
    end else if (state == SEED) begin
      pat_cnt <= '0;
    end else if (state == RUN) begin
      pat_cnt <= pat_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || state != DRAIN) begin
      drain_cnt <= '0;
    end else begin
      drain_cnt <= drain_cnt + DRAIN_W'(1);
    end
  end

  // Tags each response bit with whether a pattern was applied RESP_LAT cycles ago.
  always_ff @(posedge clk) begin
    if (!rst || abort_take) begin
      vpipe <= '0;
    end else begin
      vpipe[0] <= tpg_en;
      for (int i = 1; i < RESP_LAT; i++) vpipe[i] <= vpipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pass <= 1'b0;
    end else if (accept || abort_take) begin
      pass <= 1'b0;
    end else if (state == CHECK) begin
      pass <= (ones_count == golden_q);
    end
  end

  lbist_ones_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_ones (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .inc   (vpipe[RESP_LAT-1] & resp_bit),
    .count (ones_count)
  );

endmodule

// File: tb/tb_lbist_controller.sv
// Directed bench: main instance (CNT_BITS=32, RESP_LAT=2) plus a 3-bit-count
// instance for the wrap case; cycle c is the period following edge c-1.
module tb_lbist_controller;

  logic        clk;
  logic        rst;
  logic        start, abort, resp_bit;
  logic [15:0] num_patterns;
  logic [31:0] golden;
  logic        tpg_load, tpg_en, busy, done, pass;
  logic [31:0] ones_count;

  logic        b_start, b_abort, b_resp;
  logic [15:0] b_num;
  logic [2:0]  b_golden;
  logic        b_load, b_en, b_busy, b_done, b_pass;
  logic [2:0]  b_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  lbist_controller #(.PAT_BITS(16), .CNT_BITS(32), .RESP_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .num_patterns(num_patterns), .golden(golden), .resp_bit(resp_bit),
    .tpg_load(tpg_load), .tpg_en(tpg_en), .busy(busy), .done(done),
    .pass(pass), .ones_count(ones_count)
  );

  lbist_controller #(.PAT_BITS(16), .CNT_BITS(3), .RESP_LAT(2)) dut3 (
    .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
    .num_patterns(b_num), .golden(b_golden), .resp_bit(b_resp),
    .tpg_load(b_load), .tpg_en(b_en), .busy(b_busy), .done(b_done),
    .pass(b_pass), .ones_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One session on the main instance; start is sampled at the edge ending cycle 0.
  task automatic run(input logic [15:0] n, input logic [31:0] g, input logic r,
                     input int abort_cyc,
                     output int done_c, output int en_first, output int en_last,
                     output int en_n, output int load_c, output int overlap,
                     output logic pass_d, output logic [31:0] cnt_d,
                     output logic busy_ab, output logic [31:0] cnt_ab);
    done_c = -1; en_first = -1; en_last = -1; en_n = 0; load_c = -1; overlap = 0;
    pass_d = 1'b0; cnt_d = '0; busy_ab = 1'b1; cnt_ab = '0;
    tick();
    num_patterns = n; golden = g; resp_bit = r; start = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      tick();
      start = 1'b0;
      if (c == 1) begin
        num_patterns = ~n;
        golden = ~g;
      end
      abort = (c == abort_cyc);
      if (tpg_en) begin
        if (en_first < 0) en_first = c;
        en_last = c;
        en_n++;
      end
      if (tpg_load) load_c = c;
      if (tpg_load && tpg_en) overlap++;
      if (abort_cyc > 0 && c == abort_cyc + 1) begin
        busy_ab = busy;
        cnt_ab  = ones_count;
      end
      if (done) begin
        done_c = c;
        pass_d = pass;
        cnt_d  = ones_count;
        break;
      end
      if (abort_cyc > 0 && c == abort_cyc + 3) begin
        cnt_d = ones_count;
        break;
      end
    end
    abort = 1'b0;
  endtask

  int          dc, ef, el, en, lc, ov;
  logic        pd, bab;
  logic [31:0] cd, cab;
  int          loads[$];
  int          dones[$];
  logic        idle_gap;
  logic [2:0]  w11, w12;

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; resp_bit = 1'b0;
    num_patterns = '0; golden = '0;
    b_start = 1'b0; b_abort = 1'b0; b_resp = 1'b0; b_num = '0; b_golden = '0;
    tick(); tick();
    check("rst_outputs", {tpg_load, tpg_en, busy, done, pass}, 5'b0);
    check("rst_count", ones_count, 0);
    rst = 1'b1;

    // N=4, all ones, golden=4
    run(16'd4, 32'd4, 1'b1, 0, dc, ef, el, en, lc, ov, pd, cd, bab, cab);
    check("t1_done_cyc", dc, 9);
    check("t1_en_first", ef, 2);
    check("t1_en_last", el, 5);
    check("t1_en_count", en, 4);
    check("t1_load_cyc", lc, 1);
    check("t1_no_overlap", ov, 0);
    check("t1_pass", pd, 1);
    check("t1_count", cd, 4);

    // Same with all zeros: mismatch against golden=4
    run(16'd4, 32'd4, 1'b0, 0, dc, ef, el, en, lc, ov, pd, cd, bab, cab);
    check("t2_done_cyc", dc, 9);
    check("t2_pass", pd, 0);
    check("t2_count", cd, 0);

    // Zero patterns
    run(16'd0, 32'd0, 1'b1, 0, dc, ef, el, en, lc, ov, pd, cd, bab, cab);
    check("t3_en_count", en, 0);
    check("t3_done_cyc", dc, 5);
    check("t3_pass", pd, 1);
    check("t3_load_cyc", lc, 1);

    // Abort in RUN at cycle 4
    run(16'd8, 32'd8, 1'b1, 4, dc, ef, el, en, lc, ov, pd, cd, bab, cab);
    check("ab_no_done", dc, -1);
    check("ab_busy_c5", bab, 0);
    check("ab_pass", pass, 0);
    check("ab_count_held", cd, cab);
    run(16'd4, 32'd4, 1'b1, 0, dc, ef, el, en, lc, ov, pd, cd, bab, cab);
    check("ab_restart_done", dc, 9);
    check("ab_restart_pass", pd, 1);

    // 3-bit count wraps 7 -> 0 -> 1 over nine ones
    tick();
    b_num = 16'd9; b_golden = 3'd1; b_resp = 1'b1; b_start = 1'b1;
    dc = -1; pd = 1'b0; w11 = '0; w12 = '0;
    for (int c = 1; c <= 60; c++) begin
      tick();
      b_start = 1'b0;
      if (c == 11) w11 = b_cnt;
      if (c == 12) w12 = b_cnt;
      if (b_done) begin
        dc = c;
        pd = b_pass;
        break;
      end
    end
    check("wrap_c11", w11, 7);
    check("wrap_c12", w12, 0);
    check("wrap_done_cyc", dc, 14);
    check("wrap_pass", pd, 1);
    check("wrap_final", b_cnt, 1);

    // Reset asserted in the first DRAIN cycle (cycle 6)
    tick();
    num_patterns = 16'd4; golden = 32'd4; resp_bit = 1'b1; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    check("mid_busy_c6", busy, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_outputs", {tpg_load, tpg_en, busy, done, pass}, 5'b0);
    check("mid_rst_count", ones_count, 0);

    // Start held high: back-to-back N=1 sessions
    tick();
    num_patterns = 16'd1; golden = 32'd1; resp_bit = 1'b1; start = 1'b1;
    idle_gap = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (tpg_load) loads.push_back(c);
      if (done) dones.push_back(c);
      if (c == 7) idle_gap = !busy;
    end
    start = 1'b0;
    check("b2b_n_done", dones.size(), 2);
    check("b2b_n_load", loads.size(), 3);
    check("b2b_done0", (dones.size() > 0) ? dones[0] : -1, 6);
    check("b2b_done1", (dones.size() > 1) ? dones[1] : -1, 13);
    check("b2b_load1", (loads.size() > 1) ? loads[1] : -1, 8);
    check("b2b_load2", (loads.size() > 2) ? loads[2] : -1, 15);
    check("b2b_idle_gap", idle_gap, 1);

    for (int c = 0; c < 30 && busy; c++) tick();
    check("end_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
